// File: rtl/uart_tx_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Brief    : Shared types for the uart_tx scheduler (FSM states, sources).
//  Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    START     = 3'd2,
    WAIT_BUSY = 3'd3,
    WAIT_DONE = 3'd4
  } sched_state_t;

  typedef enum logic {
    SRC_CORE = 1'b0,
    SRC_DBG  = 1'b1
  } src_t;

  // Bytes per core word, sent LSB first.
  localparam int CORE_BYTES = 4;

endpackage
`default_nettype wire

// File: rtl/uart_tx_sched_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo
//  Brief    : Single-clock FIFO, power-of-2 depth, extra pointer bit for
//             full/empty. A push into a full FIFO is refused even when a pop
//             happens in the same cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  // Next pointer and storage contents for accepted push/pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q[AW-1:0]] = din;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // Pointers flush on reset; that alone discards buffered entries.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_sched.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_sched
//  Brief    : Round-robin scheduler sharing one uart_tx between a 32-bit core
//             word source and an 8-bit debug byte source, each FIFO-buffered.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int CORE_DEPTH = 16,
  parameter int DBG_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] core_data,
  input  logic        core_valid,
  output logic        core_ready,
  input  logic [7:0]  dbg_data,
  input  logic        dbg_valid,
  output logic        dbg_ready,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic        idle,
  output logic [15:0] byte_count
);

  sched_state_t state_q, state_d;
  src_t         grant_q, grant_d;
  src_t         last_grant_q, last_grant_d;
  logic [31:0]  hold_q, hold_d;
  logic [1:0]   byte_idx_q, byte_idx_d;
  logic [1:0]   last_idx_q, last_idx_d;
  logic [15:0]  byte_count_q, byte_count_d;

  logic [31:0]  core_dout;
  logic [7:0]   dbg_dout;
  logic         core_full, core_empty, dbg_full, dbg_empty;
  logic         core_pop, dbg_pop;
  logic         load_en;
  src_t         load_src;
  logic         arb_any;
  src_t         arb_src;

  assign core_ready = !core_full;
  assign dbg_ready  = !dbg_full;

  sync_fifo #(.WIDTH(32), .DEPTH(CORE_DEPTH)) u_core_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (core_valid && !core_full),
    .din   (core_data),
    .pop   (core_pop),
    .dout  (core_dout),
    .full  (core_full),
    .empty (core_empty)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(DBG_DEPTH)) u_dbg_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (dbg_valid && !dbg_full),
    .din   (dbg_data),
    .pop   (dbg_pop),
    .dout  (dbg_dout),
    .full  (dbg_full),
    .empty (dbg_empty)
  );

  // Round robin between the sources; a lone non-empty source always wins.
  always_comb begin
    arb_any = !core_empty || !dbg_empty;
    arb_src = SRC_CORE;
    if (!core_empty && !dbg_empty) begin
      arb_src = (last_grant_q == SRC_DBG) ? SRC_CORE : SRC_DBG;
    end else if (core_empty) begin
      arb_src = SRC_DBG;
    end
  end

  // Scheduler FSM. When the last byte of an entry finishes and more data is
  // waiting, the next entry is loaded straight from WAIT_DONE so the next
  // start follows the fall of tx_busy by one cycle even across grants.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    hold_d       = hold_q;
    byte_idx_d   = byte_idx_q;
    last_idx_d   = last_idx_q;
    byte_count_d = byte_count_q;
    load_en      = 1'b0;
    load_src     = grant_q;
    core_pop     = 1'b0;
    dbg_pop      = 1'b0;

    case (state_q)
      IDLE: begin
        if (arb_any) begin
          grant_d = arb_src;
          state_d = LOAD;
        end
      end
      LOAD: begin
        load_en  = 1'b1;
        load_src = grant_q;
        state_d  = START;
      end
      START: begin
        byte_count_d = byte_count_q + 16'd1;
        state_d      = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (byte_idx_q < last_idx_q) begin
            byte_idx_d = byte_idx_q + 2'd1;
            state_d    = START;
          end else if (arb_any) begin
            load_en  = 1'b1;
            load_src = arb_src;
            grant_d  = arb_src;
            state_d  = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load_en) begin
      byte_idx_d   = 2'd0;
      last_grant_d = load_src;
      if (load_src == SRC_CORE) begin
        core_pop   = 1'b1;
        hold_d     = core_dout;
        last_idx_d = 2'(CORE_BYTES - 1);
      end else begin
        dbg_pop    = 1'b1;
        hold_d     = {24'h0, dbg_dout};
        last_idx_d = 2'd0;
      end
    end
  end

  // Scheduler state; last_grant resets to DBG so the core wins the first tie.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= IDLE;
      grant_q      <= SRC_CORE;
      last_grant_q <= SRC_DBG;
      hold_q       <= '0;
      byte_idx_q   <= '0;
      last_idx_q   <= '0;
      byte_count_q <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      hold_q       <= hold_d;
      byte_idx_q   <= byte_idx_d;
      last_idx_q   <= last_idx_d;
      byte_count_q <= byte_count_d;
    end
  end

  assign tx_start   = (state_q == START);
  assign tx_data    = hold_q[{byte_idx_q, 3'b000} +: 8];
  assign idle       = (state_q == IDLE) && core_empty && dbg_empty;
  assign byte_count = byte_count_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_sched
//  Brief    : Directed bench for uart_tx_sched with a simple uart_tx busy model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_sched;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] core_data;
  logic        core_valid;
  logic        core_ready;
  logic [7:0]  dbg_data;
  logic        dbg_valid;
  logic        dbg_ready;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic        idle;
  logic [15:0] byte_count;

  int total = 0;
  int bad   = 0;

  int busy_len = 20;
  logic [7:0] busy_cnt;

  // monitor state (written only by the monitor process)
  logic [7:0] rx_q [$];
  int   cyc = 0;
  int   fall_cyc = 0;
  logic prev_busy = 1'b0;
  logic armed = 1'b0;
  logic [7:0] cur_byte = 8'h00;
  int   n_starts = 0;
  int   n_start_busy = 0;
  int   n_gap_err = 0;
  int   n_unstable = 0;

  int rd_idx = 0;

  uart_tx_sched #(.CORE_DEPTH(16), .DBG_DEPTH(8)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .core_data  (core_data),
    .core_valid (core_valid),
    .core_ready (core_ready),
    .dbg_data   (dbg_data),
    .dbg_valid  (dbg_valid),
    .dbg_ready  (dbg_ready),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_busy    (tx_busy),
    .idle       (idle),
    .byte_count (byte_count)
  );

  always #5 clk = ~clk;

  // uart_tx model: busy rises the cycle after tx_start, lasts busy_len cycles
  always @(posedge clk) begin
    if (!rstn)               busy_cnt <= 8'd0;
    else if (tx_start)       busy_cnt <= 8'(busy_len);
    else if (busy_cnt != 0)  busy_cnt <= busy_cnt - 8'd1;
  end
  assign tx_busy = (busy_cnt != 8'd0);

  // Monitor: capture bytes, watch start spacing and tx_data stability
  always @(negedge clk) begin
    cyc       <= cyc + 1;
    prev_busy <= tx_busy;
    if (prev_busy && !tx_busy) fall_cyc <= cyc;
    if (idle) armed <= 1'b0;
    if (tx_start) begin
      n_starts <= n_starts + 1;
      if (tx_busy) n_start_busy <= n_start_busy + 1;
      if (armed && (cyc != fall_cyc + 1)) n_gap_err <= n_gap_err + 1;
      armed    <= 1'b1;
      cur_byte <= tx_data;
      rx_q.push_back(tx_data);
    end else if (tx_busy && (tx_data != cur_byte)) begin
      n_unstable <= n_unstable + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_core(input logic [31:0] w, input int bound);
    logic r;
    logic ok = 1'b0;
    core_data  = w;
    core_valid = 1'b1;
    for (int k = 0; k < bound && !ok; k++) begin
      r = core_ready;
      tick();
      ok = r;
    end
    core_valid = 1'b0;
    chk("push_core_timeout", {31'd0, ok}, 32'd1);
  endtask

  task automatic push_dbg(input logic [7:0] b);
    logic r;
    dbg_data  = b;
    dbg_valid = 1'b1;
    r = dbg_ready;
    tick();
    dbg_valid = 1'b0;
    chk("push_dbg_ready", {31'd0, r}, 32'd1);
  endtask

  task automatic push_both(input logic [31:0] w, input logic [7:0] b);
    core_data  = w;
    core_valid = 1'b1;
    dbg_data   = b;
    dbg_valid  = 1'b1;
    chk("both_ready", {30'd0, core_ready, dbg_ready}, 32'd3);
    tick();
    core_valid = 1'b0;
    dbg_valid  = 1'b0;
  endtask

  task automatic wait_bytes(input int n, input int bound);
    logic ok = 1'b0;
    for (int k = 0; k < bound && !ok; k++) begin
      if (rx_q.size() >= rd_idx + n) ok = 1'b1;
      else tick();
    end
    chk("wait_bytes_timeout", {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_idle(input int bound);
    logic ok = 1'b0;
    for (int k = 0; k < bound && !ok; k++) begin
      if (idle && !tx_busy) ok = 1'b1;
      else tick();
    end
    chk("wait_idle_timeout", {31'd0, ok}, 32'd1);
  endtask

  task automatic expect_byte(input string tag, input logic [7:0] exp);
    chk(tag, {24'd0, rx_q[rd_idx]}, {24'd0, exp});
    rd_idx++;
  endtask

  initial begin
    logic [7:0]  exp5 [5];
    logic [31:0] w;
    int          starts_before;

    rstn = 1'b0; core_valid = 1'b0; core_data = '0; dbg_valid = 1'b0; dbg_data = '0;
    repeat (3) tick();

    // reset values
    chk("rst_tx_start",   {31'd0, tx_start}, 32'd0);
    chk("rst_tx_data",    {24'd0, tx_data}, 32'd0);
    chk("rst_byte_count", {16'd0, byte_count}, 32'd0);
    chk("rst_idle",       {31'd0, idle}, 32'd1);
    chk("rst_readies",    {30'd0, core_ready, dbg_ready}, 32'd3);
    rstn = 1'b1;
    tick();

    // tie right after reset: core wins
    push_both(32'hA0B0C0D0, 8'h5A);
    wait_bytes(5, 400);
    exp5 = '{8'hD0, 8'hC0, 8'hB0, 8'hA0, 8'h5A};
    for (int i = 0; i < 5; i++) expect_byte("t2a_byte", exp5[i]);
    wait_idle(100);

    // single core word with first-start latency
    push_core(32'h44332211, 4);
    chk("lat_idle",  {31'd0, tx_start}, 32'd0);
    tick();
    chk("lat_load",  {31'd0, tx_start}, 32'd0);
    tick();
    chk("lat_start", {31'd0, tx_start}, 32'd1);
    chk("lat_data",  {24'd0, tx_data}, 32'h11);
    tick();
    chk("lat_pulse", {31'd0, tx_start}, 32'd0);
    wait_bytes(4, 400);
    exp5 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
    for (int i = 0; i < 4; i++) expect_byte("t1_byte", exp5[i]);
    wait_idle(100);

    // tie after a core grant: debug wins
    push_both(32'h01020304, 8'h77);
    wait_bytes(5, 400);
    exp5 = '{8'h77, 8'h04, 8'h03, 8'h02, 8'h01};
    for (int i = 0; i < 5; i++) expect_byte("t2b_byte", exp5[i]);
    wait_idle(100);

    // debug byte arriving mid-word waits for the whole word
    push_core(32'hDDCCBBAA, 4);
    wait_bytes(2, 200);
    push_dbg(8'hEE);
    wait_bytes(5, 400);
    exp5 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    for (int i = 0; i < 5; i++) expect_byte("t3_byte", exp5[i]);
    wait_idle(100);
    chk("t3_byte_count", {16'd0, byte_count}, 32'd19);

    // core FIFO full while a stretched debug byte is in flight
    busy_len = 60;
    push_dbg(8'h99);
    wait_bytes(1, 20);
    for (int i = 0; i < 16; i++) push_core(32'h03020100 + 32'(i) * 32'h04040404, 2);
    chk("t4_full_ready", {31'd0, core_ready}, 32'd0);
    core_data  = 32'h03020100 + 32'd16 * 32'h04040404;
    core_valid = 1'b1;
    repeat (5) tick();
    chk("t4_still_full", {31'd0, core_ready}, 32'd0);
    push_core(32'h03020100 + 32'd16 * 32'h04040404, 100);
    busy_len = 20;
    wait_bytes(69, 4000);
    expect_byte("t4_dbg", 8'h99);
    for (int k = 0; k < 68; k++) expect_byte("t4_byte", 8'(k));
    wait_idle(100);
    chk("t4_byte_count", {16'd0, byte_count}, 32'd88);

    // reset in the middle of a word
    push_core(32'h88776655, 4);
    push_core(32'h12345678, 4);
    wait_bytes(2, 200);
    rstn = 1'b0;
    tick();
    chk("t5_tx_start",   {31'd0, tx_start}, 32'd0);
    chk("t5_idle",       {31'd0, idle}, 32'd1);
    chk("t5_byte_count", {16'd0, byte_count}, 32'd0);
    chk("t5_tx_data",    {24'd0, tx_data}, 32'd0);
    chk("t5_readies",    {30'd0, core_ready, dbg_ready}, 32'd3);
    rstn = 1'b1;
    tick();
    starts_before = n_starts;
    repeat (60) tick();
    chk("t5_no_start", 32'(n_starts), 32'(starts_before));
    chk("t5_idle_after", {31'd0, idle}, 32'd1);
    rd_idx = rx_q.size();

    // 40 words through the 16-deep FIFO
    for (int i = 0; i < 40; i++) begin
      w = 32'h03020100 + 32'(i) * 32'h04040404;
      push_core(w, 300);
    end
    wait_bytes(160, 6000);
    for (int k = 0; k < 160; k++) expect_byte("t6_byte", 8'(k));
    wait_idle(100);
    chk("t6_byte_count", {16'd0, byte_count}, 32'd160);

    // protocol watchers
    chk("start_while_busy", 32'(n_start_busy), 32'd0);
    chk("b2b_gap",          32'(n_gap_err), 32'd0);
    chk("tx_data_stable",   32'(n_unstable), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
